// File: rtl/macc_addr_seq.sv
// macc_addr_seq: sequencer in front of the 2D address counter.
// Latches and validates a matrix shape, holds the counter cleared outside
// RUN, steps it on each accepted request and forwards the counter outputs
// as a valid/ready request stream with end-of-row / end-of-matrix flags.
module macc_addr_seq #(
    parameter int MSB = 11
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic         abort,
    input  logic [MSB:0] row_max,
    input  logic [MSB:0] col_max,
    output logic         ctr_rst_l,
    output logic         ctr_inc,
    output logic [MSB:0] ctr_row_max,
    output logic [MSB:0] ctr_col_max,
    input  logic [MSB:0] ctr_a,
    input  logic [MSB:0] ctr_row,
    input  logic [MSB:0] ctr_col,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [MSB:0] out_addr,
    output logic [MSB:0] out_row,
    output logic [MSB:0] out_col,
    output logic         out_last_col,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHK,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [MSB:0] ONE = {{MSB{1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [MSB:0] row_max_q, row_max_d;
    logic [MSB:0] col_max_q, col_max_d;
    logic         cfg_err_q, cfg_err_d;
    logic         run;
    logic         last_col;
    logic         last;
    logic         legal;

    // A shape is legal when col_max is a low-order mask (not all ones) and
    // the row index still fits above the column bits of the linear address.
    function automatic logic cfg_legal(input logic [MSB:0] rm, input logic [MSB:0] cm);
        int           k;
        logic         mask_ok;
        logic         full;
        logic [MSB:0] hi;
        k = 0;
        for (int i = 0; i <= MSB; i++) begin
            if (cm[i]) k++;
        end
        mask_ok = ((cm & (cm + ONE)) == '0);
        full    = &cm;
        hi      = rm >> (MSB + 1 - k);
        return mask_ok && !full && (hi == '0);
    endfunction

    assign legal    = cfg_legal(row_max_q, col_max_q);
    assign run      = (state_q == S_RUN);
    assign last_col = run && (ctr_col == col_max_q);
    assign last     = last_col && (ctr_row == row_max_q);

    // Counter control: cleared in every state but RUN, stepped on non-final accepts
    assign ctr_rst_l   = run;
    assign ctr_inc     = run && out_ready && !last;
    assign ctr_row_max = row_max_q;
    assign ctr_col_max = col_max_q;

    // Request stream: counter outputs are already registered, forwarded as-is
    assign out_valid    = run;
    assign out_addr     = run ? ctr_a   : '0;
    assign out_row      = run ? ctr_row : '0;
    assign out_col      = run ? ctr_col : '0;
    assign out_last_col = last_col;
    assign out_last     = last;

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign cfg_err = cfg_err_q;

    // State, latched shape and error-pulse registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            row_max_q <= '0;
            col_max_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_max_q <= row_max_d;
            col_max_q <= col_max_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state logic: start only from IDLE, abort from any busy state
    always_comb begin
        state_d   = state_q;
        row_max_d = row_max_q;
        col_max_d = col_max_q;
        cfg_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CHK;
                    row_max_d = row_max;
                    col_max_d = col_max;
                end
            end
            S_CHK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (legal) begin
                    state_d = S_RUN;
                end else begin
                    state_d   = S_IDLE;
                    cfg_err_d = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last && out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_macc_addr_seq.sv
// Testbench for macc_addr_seq: a behavioural 2D counter closes the loop, and
// each presented request is compared with the element index derived from the
// number of accepts so far (row = idx / cols, col = idx % cols).
module tb_macc_addr_seq;

    localparam int MSB = 11;
    localparam int W   = MSB + 1;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic         abort;
    logic [MSB:0] row_max;
    logic [MSB:0] col_max;
    logic         ctr_rst_l;
    logic         ctr_inc;
    logic [MSB:0] ctr_row_max;
    logic [MSB:0] ctr_col_max;
    logic [MSB:0] ctr_a;
    logic [MSB:0] ctr_row;
    logic [MSB:0] ctr_col;
    logic         out_valid;
    logic         out_ready;
    logic [MSB:0] out_addr;
    logic [MSB:0] out_row;
    logic [MSB:0] out_col;
    logic         out_last_col;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         cfg_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    macc_addr_seq #(.MSB(MSB)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .abort        (abort),
        .row_max      (row_max),
        .col_max      (col_max),
        .ctr_rst_l    (ctr_rst_l),
        .ctr_inc      (ctr_inc),
        .ctr_row_max  (ctr_row_max),
        .ctr_col_max  (ctr_col_max),
        .ctr_a        (ctr_a),
        .ctr_row      (ctr_row),
        .ctr_col      (ctr_col),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last_col (out_last_col),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    // Behavioural downstream 2D address counter
    always @(posedge CLK) begin
        if (!ctr_rst_l) begin
            ctr_a   <= '0;
            ctr_row <= '0;
            ctr_col <= '0;
        end else if (ctr_inc) begin
            ctr_a <= ctr_a + W'(1);
            if (ctr_col == ctr_col_max) begin
                ctr_col <= '0;
                ctr_row <= ctr_row + W'(1);
            end else begin
                ctr_col <= ctr_col + W'(1);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready
    // abort_at: abort asserted together with that (1-based) accept, -1 none
    // rst_at: RST (with start) asserted while that element index is presented, -1 none
    task automatic run_pass(input int rm, input int cm, input int mode,
                            input int abort_at, input int rst_at);
        int count;
        int idx;
        int cyc;
        bit rdy;
        bit fin;
        bit ab;
        count = (rm + 1) * (cm + 1);
        row_max = W'(rm);
        col_max = W'(cm);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        row_max = W'($urandom);
        col_max = W'($urandom);
        chk("chk_busy", 32'(busy), 1);
        chk("chk_valid", 32'(out_valid), 0);
        chk("chk_ctr_rst_l", 32'(ctr_rst_l), 0);
        chk("lat_row_max", 32'(ctr_row_max), 32'(rm));
        chk("lat_col_max", 32'(ctr_col_max), 32'(cm));
        tick();
        idx = 0;
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            if (cyc > 4 * count + 20) begin
                chk("timeout_accepts", 32'(idx), 32'(count));
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            ab = (abort_at == idx + 1) && rdy;
            abort = ab;
            if (rst_at == idx) begin
                RST     = 1'b1;
                start   = 1'b1;
                row_max = W'(5);
                col_max = W'(1);
            end
            #1;
            chk("valid", 32'(out_valid), 1);
            chk("addr", 32'(out_addr), 32'(idx));
            chk("row", 32'(out_row), 32'(idx / (cm + 1)));
            chk("col", 32'(out_col), 32'(idx % (cm + 1)));
            chk("last_col", 32'(out_last_col), 32'((idx % (cm + 1)) == cm));
            chk("last", 32'(out_last), 32'(idx == count - 1));
            chk("inc", 32'(ctr_inc), 32'(rdy && (idx != count - 1)));
            chk("run_done", 32'(done), 0);
            tick();
            if (rst_at == idx) begin
                chk("rst_valid", 32'(out_valid), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_cfg_err", 32'(cfg_err), 0);
                chk("rst_ctr_rst_l", 32'(ctr_rst_l), 0);
                chk("rst_inc", 32'(ctr_inc), 0);
                chk("rst_addr", 32'(out_addr), 0);
                chk("rst_row_max", 32'(ctr_row_max), 0);
                chk("rst_col_max", 32'(ctr_col_max), 0);
                RST   = 1'b0;
                start = 1'b0;
                tick();
                chk("rst_start_ignored", 32'(busy), 0);
                return;
            end
            if (ab) begin
                abort = 1'b0;
                chk("abort_valid", 32'(out_valid), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_cfg_err", 32'(cfg_err), 0);
                return;
            end
            if (rdy) begin
                if (idx == count - 1) fin = 1'b1;
                idx++;
            end
            cyc++;
        end
        out_ready = 1'($urandom_range(0, 1));
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_valid", 32'(out_valid), 0);
        chk("accept_count", 32'(idx), 32'(count));
        tick();
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_ctr_rst_l", 32'(ctr_rst_l), 0);
    endtask

    task automatic bad_cfg(input int rm, input int cm);
        row_max = W'(rm);
        col_max = W'(cm);
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_chk_busy", 32'(busy), 1);
        chk("bad_chk_err", 32'(cfg_err), 0);
        chk("bad_chk_valid", 32'(out_valid), 0);
        tick();
        chk("bad_err_pulse", 32'(cfg_err), 1);
        chk("bad_busy", 32'(busy), 0);
        chk("bad_valid", 32'(out_valid), 0);
        tick();
        chk("bad_err_clear", 32'(cfg_err), 0);
        chk("bad_valid2", 32'(out_valid), 0);
    endtask

    // Legal iff cols is a power of two below 2^W and the element count fits the address space
    function automatic bit shape_ok(input int rm, input int cm);
        bit pow2;
        pow2 = 1'b0;
        for (int p = 0; p < W; p++) begin
            if (cm + 1 == (1 << p)) pow2 = 1'b1;
        end
        return pow2 && ((rm + 1) * (cm + 1) <= (1 << W));
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rm;
        int cm;
        RST       = 1'b1;
        start     = 1'b1;
        abort     = 1'b0;
        out_ready = 1'b0;
        row_max   = W'(3);
        col_max   = W'(3);
        repeat (3) tick();
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_cfg_err", 32'(cfg_err), 0);
        chk("reset_ctr_rst_l", 32'(ctr_rst_l), 0);
        chk("reset_inc", 32'(ctr_inc), 0);
        chk("reset_row_max", 32'(ctr_row_max), 0);
        chk("reset_col_max", 32'(ctr_col_max), 0);
        chk("reset_last", 32'(out_last), 0);
        RST   = 1'b0;
        start = 1'b0;
        tick();
        chk("post_reset_idle", 32'(busy), 0);

        run_pass(2, 3, 0, -1, -1);
        run_pass(2, 3, 1, -1, -1);
        bad_cfg(0, 5);
        bad_cfg(1024, 7);
        bad_cfg(0, 4095);
        run_pass(0, 0, 0, -1, -1);
        run_pass(3, 3, 0, 5, -1);
        run_pass(1, 1, 0, -1, -1);
        run_pass(3, 3, 0, -1, 6);
        run_pass(2, 3, 2, -1, -1);
        run_pass(511, 7, 0, 3, -1);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) cm = (1 << $urandom_range(0, 4)) - 1;
            else cm = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) rm = int'($urandom_range(0, 7));
            else rm = int'($urandom_range(0, 4095));
            if (!shape_ok(rm, cm)) begin
                bad_cfg(rm, cm);
            end else if ((rm + 1) * (cm + 1) > 64) begin
                run_pass(rm, cm, 2, int'($urandom_range(1, 8)), -1);
            end else begin
                run_pass(rm, cm, 2, -1, -1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
